// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output pair with dead time, one instance per channel.
// Only built when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DEADTIME_W-1:0] deadtime,
    input  logic                  pwm_i,
    output logic                  hi_o,
    output logic                  lo_o
);

    typedef enum logic [1:0] {BOTH_OFF, HI_ON, LO_ON} dt_state_e;

    dt_state_e             state_q, state_d;
    logic [DEADTIME_W-1:0] dcnt_q, dcnt_d;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            BOTH_OFF: begin
                // Counter runs from the partner's falling edge, not from pwm_i.
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - 1'b1;
                end else begin
                    state_d = pwm_i ? HI_ON : LO_ON;
                end
            end
            HI_ON: begin
                if (!pwm_i) begin
                    if (deadtime == '0) begin
                        state_d = LO_ON;
                    end else begin
                        state_d = BOTH_OFF;
                        dcnt_d  = deadtime - 1'b1;
                    end
                end
            end
            LO_ON: begin
                if (pwm_i) begin
                    if (deadtime == '0) begin
                        state_d = HI_ON;
                    end else begin
                        state_d = BOTH_OFF;
                        dcnt_d  = deadtime - 1'b1;
                    end
                end
            end
            default: state_d = BOTH_OFF;
        endcase
        if (!enable) begin
            state_d = BOTH_OFF;
            dcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOTH_OFF;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign hi_o = (state_q == HI_ON);
    assign lo_o = (state_q == LO_ON);

endmodule
`endif

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled counter, edge/center modes, shadowed settings.
// Define PWM_DEADTIME_EN for complementary outputs with dead time.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = 8
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEADTIME_W = 4
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center_mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic                      update_pending,
    output logic                      period_start,
`ifdef PWM_DEADTIME_EN
    input  logic [DEADTIME_W-1:0]     deadtime,
    output logic [CHANNELS-1:0]       pwm_out_n,
`endif
    output logic [CHANNELS-1:0]       pwm_out
);

    logic [PRESCALE_W-1:0]     pre_q, pre_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      down_q, down_d;
    logic [WIDTH-1:0]          period_a_q, period_a_d;
    logic [WIDTH-1:0]          period_p_q, period_p_d;
    pwm_mode_e                 mode_a_q, mode_a_d;
    pwm_mode_e                 mode_p_q, mode_p_d;
    logic [CHANNELS*WIDTH-1:0] duty_a_q, duty_a_d;
    logic [CHANNELS*WIDTH-1:0] duty_p_q, duty_p_d;
    logic                      pend_q, pend_d;
    logic                      pstart_q, pstart_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      tick, boundary;

    always_comb begin
        tick       = (pre_q == prescale);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        cnt_d      = cnt_q;
        down_d     = down_q;
        boundary   = 1'b0;
        period_a_d = period_a_q;
        mode_a_d   = mode_a_q;
        duty_a_d   = duty_a_q;
        period_p_d = period_p_q;
        mode_p_d   = mode_p_q;
        duty_p_d   = duty_p_q;
        pend_d     = pend_q;

        if (tick) begin
            if (mode_a_q == PWM_EDGE) begin
                if (cnt_q >= period_a_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (period_a_q == '0) begin
                cnt_d    = '0;
                down_d   = 1'b0;
                boundary = 1'b1;
            end else if (!down_q) begin
                cnt_d  = cnt_q + 1'b1;
                down_d = (cnt_d == period_a_q);
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WIDTH'(1)) begin
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end
            end
        end

        // Shadow transfer happens before a same-cycle load is captured.
        if (pend_q && (!enable || boundary)) begin
            period_a_d = period_p_q;
            mode_a_d   = mode_p_q;
            duty_a_d   = duty_p_q;
            pend_d     = 1'b0;
            cnt_d      = '0;
            down_d     = 1'b0;
        end
        if (load) begin
            period_p_d = period;
            mode_p_d   = center_mode ? PWM_CENTER : PWM_EDGE;
            duty_p_d   = duty;
            pend_d     = 1'b1;
        end
        if (!enable) begin
            pre_d  = '0;
            cnt_d  = '0;
            down_d = 1'b0;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < duty_a_q[i*WIDTH +: WIDTH]);
        end
        pstart_d = enable && boundary;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            down_q     <= 1'b0;
            period_a_q <= '0;
            mode_a_q   <= PWM_EDGE;
            duty_a_q   <= '0;
            period_p_q <= '0;
            mode_p_q   <= PWM_EDGE;
            duty_p_q   <= '0;
            pend_q     <= 1'b0;
            pstart_q   <= 1'b0;
            pwm_q      <= '0;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            down_q     <= down_d;
            period_a_q <= period_a_d;
            mode_a_q   <= mode_a_d;
            duty_a_q   <= duty_a_d;
            period_p_q <= period_p_d;
            mode_p_q   <= mode_p_d;
            duty_p_q   <= duty_p_d;
            pend_q     <= pend_d;
            pstart_q   <= pstart_d;
            pwm_q      <= pwm_d;
        end
    end

    assign update_pending = pend_q;
    assign period_start   = pstart_q;

`ifdef PWM_DEADTIME_EN
    for (genvar i = 0; i < CHANNELS; i++) begin : g_dt
        pwm_deadtime #(
            .DEADTIME_W(DEADTIME_W)
        ) u_dt (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .deadtime(deadtime),
            .pwm_i   (pwm_q[i]),
            .hi_o    (pwm_out[i]),
            .lo_o    (pwm_out_n[i])
        );
    end
`else
    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi against a period-position reference model.
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  period = '0;
    logic          center_mode = 1'b0;
    logic [CH*W-1:0] duty = '0;
    logic          load = 1'b0;
    logic          update_pending;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    pwm_multi #(
        .WIDTH(W),
        .CHANNELS(CH),
        .PRESCALE_W(PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .prescale      (prescale),
        .period        (period),
        .center_mode   (center_mode),
        .duty          (duty),
        .load          (load),
        .update_pending(update_pending),
        .period_start  (period_start),
        .pwm_out       (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [CH-1:0] pwm;
        logic          ps;
        logic          up;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: position inside the period, in ticks.
    int m_sub, m_pos, m_P, p_P;
    bit m_c, p_c, m_pend;
    int m_duty[CH];
    int p_duty[CH];

    function automatic int plen();
        if (!m_c) return m_P + 1;
        return (m_P == 0) ? 1 : 2 * m_P;
    endfunction

    function automatic int pcnt();
        if (!m_c || m_pos <= m_P) return m_pos;
        return 2 * m_P - m_pos;
    endfunction

    function automatic bit next_is_boundary();
        return enable && reset && (m_sub == int'(prescale))
               && (m_pos + 1 >= plen());
    endfunction

    task automatic model_reset();
        m_sub = 0; m_pos = 0; m_P = 0; p_P = 0;
        m_c = 0; p_c = 0; m_pend = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            p_duty[i] = 0;
        end
    endtask

    task automatic apply();
        m_P = p_P;
        m_c = p_c;
        m_duty = p_duty;
        m_pend = 0;
        m_pos = 0;
    endtask

    task automatic capture();
        p_P = int'(period);
        p_c = center_mode;
        for (int i = 0; i < CH; i++) p_duty[i] = int'(duty[i*W +: W]);
        m_pend = 1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Predict outputs after the next edge for the inputs now applied, then advance.
    task automatic step();
        exp_t e;
        bit   bnd;
        bnd   = 0;
        e.cyc = cyc + 1;
        e.pwm = '0;
        if (!reset) begin
            model_reset();
        end else if (!enable) begin
            if (m_pend) apply();
            if (load) capture();
            m_sub = 0;
            m_pos = 0;
        end else begin
            for (int i = 0; i < CH; i++) e.pwm[i] = (pcnt() < m_duty[i]);
            if (m_sub == int'(prescale)) begin
                m_sub = 0;
                m_pos++;
                if (m_pos >= plen()) begin
                    m_pos = 0;
                    bnd = 1;
                end
            end else begin
                m_sub++;
            end
            if (bnd && m_pend) apply();
            if (load) capture();
        end
        e.ps = bnd;
        e.up = m_pend;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(int d3, int d2, int d1, int d0);
        duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic do_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
                chk("period_start", 32'(period_start), 32'(e.ps));
                chk("update_pending", 32'(update_pending), 32'(e.up));
            end
        end
    end

    initial begin : driver
        int d;
        model_reset();
        #2;
        chk("reset_pwm", 32'(pwm_out), 32'h0);
        chk("reset_ps", 32'(period_start), 32'h0);
        chk("reset_up", 32'(update_pending), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Edge mode, duties 3/0/10/5 of a 10-clk period.
        prescale = 0; center_mode = 0; period = 9;
        set_duty(5, 10, 0, 3);
        do_load();
        step();
        enable = 1'b1;
        repeat (40) step();

        // Center mode, period 4, prescale 1.
        enable = 1'b0;
        prescale = 1; center_mode = 1; period = 4;
        set_duty(2, 2, 2, 2);
        do_load();
        step();
        enable = 1'b1;
        repeat (50) step();

        // Mid-period duty change, edge mode.
        enable = 1'b0;
        prescale = 0; center_mode = 0; period = 9;
        set_duty(3, 3, 3, 3);
        do_load();
        step();
        enable = 1'b1;
        repeat (14) step();
        set_duty(7, 7, 7, 7);
        do_load();
        repeat (25) step();

        // Load exactly on a boundary edge.
        for (int k = 0; k < 40 && !next_is_boundary(); k++) step();
        set_duty(1, 9, 4, 8);
        do_load();
        repeat (25) step();

        // Asynchronous reset between clock edges.
        repeat (4) step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_pwm", 32'(pwm_out), 32'h0);
        chk("async_ps", 32'(period_start), 32'h0);
        chk("async_up", 32'(update_pending), 32'h0);
        sbq.delete();
        model_reset();
        step();
        step();
        reset = 1'b1;
        period = 9; center_mode = 0;
        set_duty(3, 3, 3, 3);
        do_load();
        repeat (25) step();

        // Center mode with period 0 and boundary-case duties.
        center_mode = 1; period = 0;
        set_duty(0, 1, 0, 1);
        do_load();
        repeat (12) step();

        // Randomized traffic.
        repeat (1500) begin
            if ($urandom_range(0, 39) == 0) begin
                enable = ~enable;
                if (!enable) prescale = PW'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                period = W'($urandom_range(0, 20));
                center_mode = 1'($urandom_range(0, 1));
                for (int i = 0; i < CH; i++) begin
                    d = $urandom_range(0, int'(period) + 2);
                    duty[i*W +: W] = W'(d);
                end
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end

        enable = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
